// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC unit with step/branch/call/return, interrupt entry/exit and vectored boot
module pc_sequencer #(
    parameter int AW        = 32,
    parameter int BOOT_PTR  = 0,
    parameter int INT_PTR   = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pc_en,
    input  logic          ilen,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    input  logic          call,
    input  logic [AW-1:0] call_target,
    input  logic          ret,
    input  logic          rti,
    input  logic          irq,
    output logic          vec_req,
    output logic [AW-1:0] vec_addr,
    input  logic [AW-1:0] vec_rdata,
    input  logic          vec_valid,
    output logic [AW-1:0] pc,
    output logic          pc_valid,
    output logic [AW-1:0] epc,
    output logic          in_isr,
    output logic          ras_ovf,
    output logic          ras_unf
);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int IW = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;

    typedef enum logic [1:0] {S_RESET, S_BOOT, S_RUN, S_INT} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] ras [RAS_DEPTH];
    logic [CW-1:0] cnt;
    logic [IW-1:0] wr_i, top_i;
    logic [AW-1:0] pc_step;
    logic          irq_q, irq_pend, irq_edge;
    logic          run, full, empty, accept;
    logic          do_rti, do_br, do_call, do_ret, take;

    assign pc_step  = pc + {{(AW-2){1'b0}}, ilen, ~ilen};
    assign full     = cnt == CW'(RAS_DEPTH);
    assign empty    = cnt == '0;
    assign wr_i     = IW'(cnt);
    assign top_i    = IW'(cnt - 1'b1);
    assign vec_req  = state == S_BOOT || state == S_INT;
    assign vec_addr = state == S_INT ? AW'(INT_PTR) : state == S_BOOT ? AW'(BOOT_PTR) : '0;
    assign pc_valid = state == S_RUN;
    assign irq_edge = irq && !irq_q && state != S_RESET;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_RESET;
        else      state <= state_nxt;
    end

    // Redirect priority decode and next state
    always_comb begin
        run       = state == S_RUN && pc_en;
        accept    = vec_req && vec_valid;
        do_rti    = run && rti;
        do_br     = run && !rti && br_taken;
        do_call   = run && !rti && !br_taken && call;
        do_ret    = run && !rti && !br_taken && !call && ret;
        take      = run && !(rti || br_taken || call || ret) && irq_pend && !in_isr;
        state_nxt = state == S_RESET ? S_BOOT : accept ? S_RUN : take ? S_INT : state;
    end

    // PC, EPC, RAS pointer, interrupt tracking and sticky stack flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= '0;
            epc      <= '0;
            in_isr   <= 1'b0;
            cnt      <= '0;
            ras_ovf  <= 1'b0;
            ras_unf  <= 1'b0;
            irq_q    <= 1'b0;
            irq_pend <= 1'b0;
        end else begin
            irq_q <= irq;
            if (irq_edge) irq_pend <= 1'b1;
            else if (state == S_INT && vec_valid) irq_pend <= 1'b0;
            if (accept) pc <= vec_rdata;
            else if (do_rti) begin
                pc     <= epc;
                in_isr <= 1'b0;
            end else if (do_br) pc <= br_target;
            else if (do_call) begin
                pc <= call_target;
                if (full) ras_ovf <= 1'b1;
                else      cnt     <= cnt + 1'b1;
            end else if (do_ret) begin
                if (empty) begin
                    pc      <= pc_step;
                    ras_unf <= 1'b1;
                end else begin
                    pc  <= ras[top_i];
                    cnt <= cnt - 1'b1;
                end
            end else if (take) begin
                epc    <= pc_step;
                in_isr <= 1'b1;
            end else if (run) pc <= pc_step;
        end
    end

    // Return-address storage; entries beyond the count are don't-care
    always_ff @(posedge clk) begin
        if (do_call && !full) ras[wr_i] <= pc_step;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized + directed scoreboard bench against a behavioural PC model
module tb_pc_sequencer;
    logic        clk = 1'b0, rst = 1'b0;
    logic        pc_en = 1'b0, ilen = 1'b0, br_taken = 1'b0, call = 1'b0, ret = 1'b0;
    logic        rti = 1'b0, irq = 1'b0, vec_valid = 1'b0;
    logic [31:0] br_target = '0, call_target = '0, vec_rdata = '0;
    logic        vec_req, pc_valid, in_isr, ras_ovf, ras_unf;
    logic [31:0] vec_addr, pc, epc;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .pc_en(pc_en), .ilen(ilen),
        .br_taken(br_taken), .br_target(br_target),
        .call(call), .call_target(call_target), .ret(ret), .rti(rti), .irq(irq),
        .vec_req(vec_req), .vec_addr(vec_addr), .vec_rdata(vec_rdata), .vec_valid(vec_valid),
        .pc(pc), .pc_valid(pc_valid), .epc(epc), .in_isr(in_isr),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, epc, va;
        logic        pv, vr, isr, ovf, unf;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0, miscompares = 0;

    localparam int M_RST = 0, M_BOOT = 1, M_RUN = 2, M_INT = 3;
    int          m_mode = M_RST;
    logic [31:0] m_pc = '0, m_epc = '0;
    logic [31:0] m_stk[$];
    logic        m_isr = 0, m_pend = 0, m_ovf = 0, m_unf = 0, m_prev = 0;

    // Behavioural model: advance one clock using the currently driven inputs
    task automatic model_step();
        exp_t        e;
        logic [31:0] nxt;
        logic        edge_seen;
        nxt = m_pc + (ilen ? 32'd2 : 32'd1);
        if (!rst) begin
            m_mode = M_RST; m_pc = '0; m_epc = '0; m_isr = 0; m_pend = 0;
            m_ovf = 0; m_unf = 0; m_prev = 0; m_stk.delete();
        end else begin
            edge_seen = irq && !m_prev && m_mode != M_RST;
            case (m_mode)
                M_RST: m_mode = M_BOOT;
                M_BOOT, M_INT: if (vec_valid) begin
                    if (m_mode == M_INT) m_pend = 0;
                    m_pc   = vec_rdata;
                    m_mode = M_RUN;
                end
                default: if (pc_en) begin
                    if (rti) begin m_pc = m_epc; m_isr = 0; end
                    else if (br_taken) m_pc = br_target;
                    else if (call) begin
                        if (m_stk.size() < 4) m_stk.push_back(nxt);
                        else m_ovf = 1;
                        m_pc = call_target;
                    end else if (ret) begin
                        if (m_stk.size() == 0) begin m_unf = 1; m_pc = nxt; end
                        else m_pc = m_stk.pop_back();
                    end else if (m_pend && !m_isr) begin
                        m_epc = nxt; m_isr = 1; m_mode = M_INT;
                    end else m_pc = nxt;
                end
            endcase
            if (edge_seen) m_pend = 1;
            m_prev = irq;
        end
        e.pc = m_pc; e.epc = m_epc; e.isr = m_isr; e.ovf = m_ovf; e.unf = m_unf;
        e.pv = m_mode == M_RUN;
        e.vr = m_mode == M_BOOT || m_mode == M_INT;
        e.va = m_mode == M_INT ? 32'd2 : 32'd0;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        pc_en = 1; ilen = 0; br_taken = 0; call = 0; ret = 0; rti = 0; vec_valid = 0;
    endtask

    task automatic vec(input logic [31:0] a);
        vec_valid = 1; vec_rdata = a; tick(); vec_valid = 0;
    endtask

    function automatic logic [31:0] rnd_target();
        case ($urandom_range(3))
            0: return 32'hFFFF_FFFF;
            1: return 32'hFFFF_FFFE;
            2: return $urandom_range(4095);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pop the expected state after every rising edge and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL no_expectation t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if ({pc, epc, vec_addr, pc_valid, vec_req, in_isr, ras_ovf, ras_unf} !==
                    {e.pc, e.epc, e.va, e.pv, e.vr, e.isr, e.ovf, e.unf}) begin
                    miscompares++;
                    $display("FAIL state t=%0t got pc=%h epc=%h va=%h pv=%b vr=%b isr=%b ovf=%b unf=%b exp pc=%h epc=%h va=%h pv=%b vr=%b isr=%b ovf=%b unf=%b",
                             $time, pc, epc, vec_addr, pc_valid, vec_req, in_isr, ras_ovf, ras_unf,
                             e.pc, e.epc, e.va, e.pv, e.vr, e.isr, e.ovf, e.unf);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        idle();
        tick(); tick();
        rst = 1;
        tick(); tick(); tick(); tick();
        vec(32'h100);
        ilen = 0; tick(); ilen = 1; tick(); ilen = 0; tick();
        pc_en = 0; tick(); tick(); pc_en = 1;
        br_taken = 1; br_target = 32'hFFFF_FFFF; tick(); br_taken = 0;
        ilen = 1; tick(); ilen = 0;
        br_taken = 1; br_target = 32'h104; tick(); br_taken = 0;
        call = 1; call_target = 32'h200; ilen = 1; tick(); call = 0; ilen = 0;
        ret = 1; tick(); ret = 0;
        for (int i = 0; i < 5; i++) begin
            call = 1; call_target = 32'h1000 + 32'(i) * 32'h100; ilen = i[0]; tick();
        end
        call = 0; ilen = 0;
        for (int i = 0; i < 5; i++) begin ret = 1; tick(); end
        ret = 0;
        br_taken = 1; br_target = 32'h104; tick(); br_taken = 0;
        pc_en = 0; irq = 1; tick(); irq = 0; tick(); pc_en = 1;
        tick(); tick();
        vec(32'h300);
        irq = 1; tick(); irq = 0; tick(); tick();
        rti = 1; tick(); rti = 0;
        tick(); tick();
        vec(32'h500);
        rti = 1; tick(); rti = 0;
        pc_en = 0; irq = 1; tick(); irq = 0; pc_en = 1;
        br_taken = 1; br_target = 32'h400; tick(); br_taken = 0;
        ilen = 1; tick(); ilen = 0;
        vec(32'h600);
        rti = 1; tick(); rti = 0;
        irq = 1; tick(); irq = 0; tick(); tick();
        rst = 0;
        #1;
        vectors++;
        if ({pc, pc_valid, in_isr, vec_req} !== 35'd0) begin
            miscompares++;
            $display("FAIL async_reset got pc=%h pv=%b isr=%b vr=%b exp all zero", pc, pc_valid, in_isr, vec_req);
        end
        tick();
        rst = 1; tick(); tick();
        vec(32'h700);
        for (int i = 0; i < 800; i++) begin
            rst         = $urandom_range(99) != 0;
            pc_en       = $urandom_range(9) < 8;
            ilen        = 1'($urandom);
            rti         = $urandom_range(19) == 0;
            br_taken    = $urandom_range(9) == 0;
            call        = $urandom_range(9) == 0;
            ret         = $urandom_range(9) == 0;
            br_target   = rnd_target();
            call_target = rnd_target();
            if ($urandom_range(9) == 0) irq = ~irq;
            vec_valid   = $urandom_range(9) < 4;
            vec_rdata   = rnd_target();
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
